// File: rtl/ddr_video_pkg.sv
// rtl/ddr_video_pkg.sv - 720p60 timing constants, reader states and RGB888 field slices
package ddr_video_pkg;

   localparam int T720_H_ACTIVE = 1280;
   localparam int T720_H_FP     = 110;
   localparam int T720_H_SYNC   = 40;
   localparam int T720_H_BP     = 220;
   localparam int T720_V_ACTIVE = 720;
   localparam int T720_V_FP     = 5;
   localparam int T720_V_SYNC   = 5;
   localparam int T720_V_BP     = 20;

   localparam int R_MSB = 23;
   localparam int R_LSB = 16;
   localparam int G_MSB = 15;
   localparam int G_LSB = 8;
   localparam int B_MSB = 7;
   localparam int B_LSB = 0;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PREFILL,
      RUN
   } rd_state_e;

   typedef struct packed {
      logic fs;
      logic de;
      logic hs;
      logic vs;
   } vid_flags_t;

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - active-first raster counters with raw DE/HS/VS decode
module video_timing_gen
   import ddr_video_pkg::*;
#(
   parameter int H_ACTIVE = T720_H_ACTIVE,
   parameter int H_FP     = T720_H_FP,
   parameter int H_SYNC   = T720_H_SYNC,
   parameter int H_BP     = T720_H_BP,
   parameter int V_ACTIVE = T720_V_ACTIVE,
   parameter int V_FP     = T720_V_FP,
   parameter int V_SYNC   = T720_V_SYNC,
   parameter int V_BP     = T720_V_BP,
   parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic [H_W-1:0] h_cnt,
   output logic [V_W-1:0] v_cnt,
   output logic           de_raw,
   output logic           hs_raw,
   output logic           vs_raw
);

   localparam logic [H_W-1:0] H_LAST   = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [V_W-1:0] V_LAST   = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
   localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
   localparam logic [H_W-1:0] HS_BEGIN = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0] VS_BEGIN = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [H_W-1:0] h_cnt_q, h_cnt_d;
   logic [V_W-1:0] v_cnt_q, v_cnt_d;

   // Disabled counters sit at 0 so timing starts on the first active pixel.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!en) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
         h_cnt_d = h_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign h_cnt  = h_cnt_q;
   assign v_cnt  = v_cnt_q;
   assign de_raw = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign hs_raw = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
   assign vs_raw = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);

endmodule

// File: rtl/ddr3_frame_reader.sv
// rtl/ddr3_frame_reader.sv - pops the DDR3 read FIFO in raster order and drives RGB888 video
module ddr3_frame_reader
   import ddr_video_pkg::*;
#(
   parameter int H_ACTIVE  = T720_H_ACTIVE,
   parameter int H_FP      = T720_H_FP,
   parameter int H_SYNC    = T720_H_SYNC,
   parameter int H_BP      = T720_H_BP,
   parameter int V_ACTIVE  = T720_V_ACTIVE,
   parameter int V_FP      = T720_V_FP,
   parameter int V_SYNC    = T720_V_SYNC,
   parameter int V_BP      = T720_V_BP,
   parameter bit HS_POL    = 1'b1,
   parameter bit VS_POL    = 1'b1,
   parameter int RD_LAT    = 1,
   parameter int LOAD_LEN  = 8,
   parameter int START_DLY = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_calib_complete,
   output logic        rd_load,
   output logic        rfifo_rden,
   input  logic [31:0] rfifo_dout,
   output logic        vid_hs,
   output logic        vid_vs,
   output logic        vid_de,
   output logic [23:0] vid_data,
   output logic        frame_start
);

   localparam int H_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int V_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam int LC_W = $clog2(LOAD_LEN + 1);
   localparam int PC_W = $clog2(START_DLY + 1);
   localparam logic [LC_W-1:0] LOAD_LAST = LC_W'(LOAD_LEN - 1);
   localparam logic [PC_W-1:0] PRE_LAST  = PC_W'(START_DLY - 1);
   localparam logic [H_W-1:0]  REW_H_END = H_W'(LOAD_LEN);
   localparam logic [V_W-1:0]  REW_V     = V_W'(V_ACTIVE + V_FP);

   logic            calib_meta_q, calib_meta_d, calib_s_q, calib_s_d;
   rd_state_e       state_q, state_d;
   logic [LC_W-1:0] load_cnt_q, load_cnt_d;
   logic [PC_W-1:0] pre_cnt_q, pre_cnt_d;
   logic            flush, run;
   logic [H_W-1:0]  h_cnt;
   logic [V_W-1:0]  v_cnt;
   logic            de_raw, hs_raw, vs_raw;
   vid_flags_t      pipe_q [RD_LAT+1];
   vid_flags_t      pipe_d [RD_LAT+1];
   logic [23:0]     vid_data_q, vid_data_d;
   logic            unused_dout_bits;

   assign unused_dout_bits = &{1'b0, rfifo_dout[31:24]};
   assign run = (state_q == RUN);

   video_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .H_W(H_W), .V_W(V_W)
   ) timing_gen (
      .clk    (clk),
      .rst    (rst),
      .en     (run),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .de_raw (de_raw),
      .hs_raw (hs_raw),
      .vs_raw (vs_raw)
   );

   always_comb begin
      calib_meta_d = init_calib_complete;
      calib_s_d    = calib_meta_q;
   end

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      pre_cnt_d  = pre_cnt_q;
      flush      = 1'b0;
      case (state_q)
         IDLE: begin
            load_cnt_d = '0;
            pre_cnt_d  = '0;
            if (calib_s_q) state_d = LOAD;
         end
         LOAD: begin
            if (load_cnt_q == LOAD_LAST) begin
               state_d    = PREFILL;
               load_cnt_d = '0;
            end else begin
               load_cnt_d = load_cnt_q + 1'b1;
            end
         end
         PREFILL: begin
            if (pre_cnt_q == PRE_LAST) begin
               state_d   = RUN;
               pre_cnt_d = '0;
            end else begin
               pre_cnt_d = pre_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
      // Losing calibration acts as a soft reset, including the video pipeline.
      if (state_q != IDLE && !calib_s_q) begin
         state_d    = IDLE;
         load_cnt_d = '0;
         pre_cnt_d  = '0;
         flush      = 1'b1;
      end
      rd_load    = (state_q == LOAD) || (run && v_cnt == REW_V && h_cnt < REW_H_END);
      rfifo_rden = run && de_raw;
   end

   // Flags enter stage 0 on the pop cycle; data is captured when its flags reach stage RD_LAT-1.
   always_comb begin
      pipe_d[0] = '{fs: run && h_cnt == '0 && v_cnt == '0, de: run && de_raw,
                    hs: run && hs_raw, vs: run && vs_raw};
      for (int i = 1; i <= RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
      vid_data_d = pipe_q[RD_LAT-1].de ?
                   {rfifo_dout[R_MSB:R_LSB], rfifo_dout[G_MSB:G_LSB], rfifo_dout[B_MSB:B_LSB]} : '0;
      if (flush) begin
         for (int i = 0; i <= RD_LAT; i++) pipe_d[i] = '0;
         vid_data_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         calib_meta_q <= 1'b0;
         calib_s_q    <= 1'b0;
         state_q      <= IDLE;
         load_cnt_q   <= '0;
         pre_cnt_q    <= '0;
         vid_data_q   <= '0;
         for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= '0;
      end else begin
         calib_meta_q <= calib_meta_d;
         calib_s_q    <= calib_s_d;
         state_q      <= state_d;
         load_cnt_q   <= load_cnt_d;
         pre_cnt_q    <= pre_cnt_d;
         vid_data_q   <= vid_data_d;
         pipe_q       <= pipe_d;
      end
   end

   assign vid_de      = pipe_q[RD_LAT].de;
   assign vid_hs      = pipe_q[RD_LAT].hs ? HS_POL : ~HS_POL;
   assign vid_vs      = pipe_q[RD_LAT].vs ? VS_POL : ~VS_POL;
   assign frame_start = pipe_q[RD_LAT].fs;
   assign vid_data    = vid_data_q;

endmodule
